// File: rtl/axi_xbar_pkg.sv
// Shared types and constants for the AXI crossbar read-response path.
package axi_xbar_pkg;

  localparam int AXI_LEN_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    DECERR = 1'b1
  } rd_resp_state_e;

endpackage

// File: rtl/axi_rd_skid_reg.sv
// R-channel output stage: single pipeline register, or a two-entry skid buffer with a
// registered input ready when AXI_RD_RESP_SKID_EN is defined.
module axi_rd_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

`ifdef AXI_RD_RESP_SKID_EN
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             main_valid_reg;
  logic             skid_valid_reg;

  // Ready depends only on skid occupancy, so it never sees out_ready combinationally.
  assign in_ready  = !skid_valid_reg;
  assign out_data  = main_reg;
  assign out_valid = main_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!main_valid_reg || out_ready) begin
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        main_valid_reg <= in_valid;
        if (in_valid) begin
          main_reg <= in_data;
        end
      end
    end else if (in_valid && !skid_valid_reg) begin
      skid_reg       <= in_data;
      skid_valid_reg <= 1'b1;
    end
  end
`else
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_data  = data_reg;
  assign out_valid = valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end
`endif

endmodule

// File: rtl/axi_crossbar_rd_resp.sv
// Per-slave read-response stage: forwards routed R beats, generates DECERR bursts and
// reports routed-burst completions. Build option AXI_RD_RESP_SKID_EN selects the skid output stage.
module axi_crossbar_rd_resp
  import axi_xbar_pkg::*;
#(
  parameter int ID_WIDTH     = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int RUSER_ENABLE = 0,
  parameter int RUSER_WIDTH  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ID_WIDTH-1:0]    s_axi_arid,
  input  logic [AXI_LEN_W-1:0]   s_axi_arlen,
  input  logic                   rc_decerr,
  input  logic                   rc_valid,
  output logic                   rc_ready,
  input  logic [ID_WIDTH-1:0]    m_rid,
  input  logic [DATA_WIDTH-1:0]  m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  input  logic [RUSER_WIDTH-1:0] m_ruser,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  output logic [ID_WIDTH-1:0]    s_axi_rid,
  output logic [DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic [RUSER_WIDTH-1:0] s_axi_ruser,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [ID_WIDTH-1:0]    s_cpl_id,
  output logic                   s_cpl_valid
);

  // Stage payload: id, data, resp, last, user, generated-beat flag.
  localparam int PW = ID_WIDTH + DATA_WIDTH + 2 + 1 + RUSER_WIDTH + 1;

  rd_resp_state_e         state_reg, state_next;
  logic                   pt_active_reg, pt_active_next;
  logic [AXI_LEN_W-1:0]   cnt_reg, cnt_next;
  logic [ID_WIDTH-1:0]    dec_id_reg, dec_id_next;
  logic                   run_reg;
  logic                   cpl_valid_reg;
  logic [ID_WIDTH-1:0]    cpl_id_reg;

  logic                   rc_fire;
  logic                   rc_take_decerr;
  logic                   routed_fire;
  logic                   stage_in_valid;
  logic                   stage_in_ready;
  logic [PW-1:0]          stage_in;
  logic [PW-1:0]          stage_out;
  logic                   out_is_gen;
  logic [RUSER_WIDTH-1:0] ruser_in;

  // run_reg keeps both ready outputs low until the first clock after reset release.
  assign rc_ready       = run_reg && (state_reg == IDLE) && !pt_active_reg;
  assign rc_fire        = rc_valid && rc_ready;
  assign rc_take_decerr = rc_fire && rc_decerr;
  assign m_rready       = run_reg && stage_in_ready && (state_reg == IDLE) && !rc_take_decerr;
  assign routed_fire    = m_rvalid && m_rready;
  assign ruser_in       = (RUSER_ENABLE != 0) ? m_ruser : '0;

  always_comb begin
    state_next     = state_reg;
    pt_active_next = pt_active_reg;
    cnt_next       = cnt_reg;
    dec_id_next    = dec_id_reg;
    stage_in_valid = 1'b0;
    stage_in       = '0;
    case (state_reg)
      IDLE: begin
        if (routed_fire) begin
          stage_in_valid = 1'b1;
          stage_in       = {m_rid, m_rdata, m_rresp, m_rlast, ruser_in, 1'b0};
          pt_active_next = !m_rlast;
        end
        if (rc_take_decerr) begin
          state_next  = DECERR;
          cnt_next    = s_axi_arlen;
          dec_id_next = s_axi_arid;
        end
      end
      DECERR: begin
        stage_in_valid = 1'b1;
        stage_in       = {dec_id_reg, {DATA_WIDTH{1'b0}}, RESP_DECERR, (cnt_reg == '0),
                          {RUSER_WIDTH{1'b0}}, 1'b1};
        if (stage_in_ready) begin
          cnt_next = cnt_reg - AXI_LEN_W'(1);
          if (cnt_reg == '0) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pt_active_reg <= 1'b0;
      cnt_reg       <= '0;
      dec_id_reg    <= '0;
      run_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pt_active_reg <= pt_active_next;
      cnt_reg       <= cnt_next;
      dec_id_reg    <= dec_id_next;
      run_reg       <= 1'b1;
    end
  end

  axi_rd_skid_reg #(
    .WIDTH (PW)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (stage_in),
    .in_valid  (stage_in_valid),
    .in_ready  (stage_in_ready),
    .out_data  (stage_out),
    .out_valid (s_axi_rvalid),
    .out_ready (s_axi_rready)
  );

  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, out_is_gen} = stage_out;

  // Generated DECERR bursts were never admitted upstream, so they must not complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_valid_reg <= 1'b0;
      cpl_id_reg    <= '0;
    end else begin
      cpl_valid_reg <= s_axi_rvalid && s_axi_rready && s_axi_rlast && !out_is_gen;
      if (s_axi_rvalid && s_axi_rready && s_axi_rlast && !out_is_gen) begin
        cpl_id_reg <= s_axi_rid;
      end
    end
  end

  assign s_cpl_valid = cpl_valid_reg;
  assign s_cpl_id    = cpl_id_reg;

endmodule

// File: tb/tb_axi_crossbar_rd_resp.sv
// Directed and randomised-stall bench for axi_crossbar_rd_resp with a beat/completion scoreboard.
module tb_axi_crossbar_rd_resp;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        gen;
    int          exp_cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic        rc_decerr;
  logic        rc_valid;
  logic        rc_ready;
  logic [7:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [0:0]  m_ruser;
  logic        m_rvalid;
  logic        m_rready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic [0:0]  s_axi_ruser;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic [7:0]  s_cpl_id;
  logic        s_cpl_valid;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  beat_t sb[$];

  axi_crossbar_rd_resp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axi_arid   (s_axi_arid),
    .s_axi_arlen  (s_axi_arlen),
    .rc_decerr    (rc_decerr),
    .rc_valid     (rc_valid),
    .rc_ready     (rc_ready),
    .m_rid        (m_rid),
    .m_rdata      (m_rdata),
    .m_rresp      (m_rresp),
    .m_rlast      (m_rlast),
    .m_ruser      (m_ruser),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .s_axi_rid    (s_axi_rid),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rlast  (s_axi_rlast),
    .s_axi_ruser  (s_axi_ruser),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_cpl_id     (s_cpl_id),
    .s_cpl_valid  (s_cpl_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Slave-side ready pattern: 0 = always ready, 1 = toggling, 2 = random.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       s_axi_rready = ~s_axi_rready;
      2:       s_axi_rready = 1'($urandom_range(0, 1));
      default: s_axi_rready = 1'b1;
    endcase
  end

  // Output monitor: pops the scoreboard per slave handshake, checks hold and completions.
  initial begin
    bit          cpl_pend;
    logic [7:0]  cpl_pend_id;
    bit          hold_pend;
    logic [43:0] held;
    cpl_pend = 0;
    cpl_pend_id = '0;
    hold_pend = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cpl_pend = 0;
        hold_pend = 0;
      end else begin
        chk("cpl_valid", s_cpl_valid, cpl_pend);
        if (cpl_pend) chk("cpl_id", s_cpl_id, cpl_pend_id);
        cpl_pend = 0;
        if (hold_pend)
          chk("hold_stable", {s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, held);
        if (s_axi_rvalid && s_axi_rready) begin
          checks++;
          assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_beat observed_id=0x%0h expected=none", s_axi_rid);
          end
          if (sb.size() != 0) begin
            chk("beat", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast},
                {sb[0].id, sb[0].data, sb[0].resp, sb[0].last});
            chk("ruser", s_axi_ruser, 0);
            if (sb[0].exp_cyc >= 0) chk("latency_cycle", cyc, sb[0].exp_cyc);
            if (sb[0].last && !sb[0].gen) begin
              cpl_pend = 1;
              cpl_pend_id = sb[0].id;
            end
            void'(sb.pop_front());
          end
        end
        hold_pend = s_axi_rvalid && !s_axi_rready;
        held = {s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic routed_beat(input logic [7:0] id, input logic [31:0] data, input logic last,
                             input bit lat);
    bit hs;
    int n;
    beat_t e;
    m_rvalid = 1'b1;
    m_rid = id;
    m_rdata = data;
    m_rresp = 2'b00;
    m_rlast = last;
    hs = 0;
    n = 0;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = m_rready;
      @(posedge clk);
      #1;
      n++;
    end
    m_rvalid = 1'b0;
    chk("routed_handshake", hs, 1);
    if (hs) begin
      e.id = id; e.data = data; e.resp = 2'b00; e.last = last; e.gen = 1'b0;
      e.exp_cyc = lat ? cyc : -1;
      sb.push_back(e);
    end
  endtask

  task automatic rc_start(input logic [7:0] id, input logic [7:0] len, input logic decerr);
    rc_valid = 1'b1;
    s_axi_arid = id;
    s_axi_arlen = len;
    rc_decerr = decerr;
  endtask

  task automatic rc_finish(input bit lat);
    bit hs;
    int n;
    beat_t e;
    hs = 0;
    n = 0;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = rc_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rc_valid = 1'b0;
    chk("rc_handshake", hs, 1);
    if (hs && rc_decerr) begin
      for (int i = 0; i <= int'(s_axi_arlen); i++) begin
        e.id = s_axi_arid; e.data = '0; e.resp = 2'b11; e.last = (i == int'(s_axi_arlen));
        e.gen = 1'b1;
        e.exp_cyc = (lat && i == 0) ? cyc + 1 : -1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_rc(input logic [7:0] id, input logic [7:0] len, input logic decerr,
                         input bit lat);
    rc_start(id, len, decerr);
    rc_finish(lat);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_remaining", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int len;
    logic [7:0] id;
    rst_n = 1'b0;
    rc_valid = 1'b0;
    rc_decerr = 1'b0;
    s_axi_arid = '0;
    s_axi_arlen = '0;
    m_rvalid = 1'b0;
    m_rid = '0;
    m_rdata = '0;
    m_rresp = '0;
    m_rlast = 1'b0;
    m_ruser = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_cpl_valid", s_cpl_valid, 0);
    chk("rst_rc_ready", rc_ready, 0);
    chk("rst_m_rready", m_rready, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_rc_ready", rc_ready, 1);

    // 1: routed burst id 3, len 3, one-cycle latency, one completion
    for (int i = 0; i < 4; i++) routed_beat(8'h03, 32'hA000_0000 + 32'(i), i == 3, 1);
    wait_drain(50);

    // 2: single-beat DECERR, two-cycle latency, no completion
    send_rc(8'h05, 8'd0, 1'b1, 1);
    wait_drain(50);
    chk("t2_rc_ready", rc_ready, 1);

    // rc without decode error is dropped
    send_rc(8'h07, 8'd4, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_rc_ready", rc_ready, 1);
    chk("drop_no_beats", sb.size(), 0);

    // Routed single beat (len 0) completes
    routed_beat(8'h11, 32'h1234_5678, 1'b1, 1);
    wait_drain(50);

    // 3: 256-beat DECERR with toggling ready
    rdy_mode = 1;
    send_rc(8'h0A, 8'd255, 1'b1, 0);
    wait_drain(2000);
    chk("t3_rc_ready", rc_ready, 1);
    rdy_mode = 0;

    // 4: rc raised mid routed burst waits for rlast, DECERR follows without interleave
    routed_beat(8'h02, 32'hB000_0000, 1'b0, 0);
    routed_beat(8'h02, 32'hB000_0001, 1'b0, 0);
    rc_start(8'h04, 8'd2, 1'b1);
    for (int i = 2; i < 8; i++) begin
      routed_beat(8'h02, 32'hB000_0000 + 32'(i), i == 7, 0);
      chk("t4_rc_ready", rc_ready, (i == 7));
    end
    rc_finish(0);
    wait_drain(100);

    // Routed beat and decerr rc together with no burst open: rc wins
    rc_start(8'h06, 8'd0, 1'b1);
    m_rvalid = 1'b1;
    m_rid = 8'h08;
    m_rdata = 32'hC0DE_0008;
    m_rlast = 1'b1;
    #2;
    chk("sim_m_rready", m_rready, 0);
    chk("sim_rc_ready", rc_ready, 1);
    rc_finish(0);
    routed_beat(8'h08, 32'hC0DE_0008, 1'b1, 0);
    wait_drain(50);

    // 5: reset in the middle of a DECERR burst
    send_rc(8'h09, 8'd30, 1'b1, 0);
    n = 0;
    while (sb.size() > 11 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_reach_cnt", sb.size(), 11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid_async", s_axi_rvalid, 0);
    chk("t5_cpl_valid", s_cpl_valid, 0);
    chk("t5_rc_ready_in_rst", rc_ready, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_rc_ready_after", rc_ready, 1);
    chk("t5_rvalid_after", s_axi_rvalid, 0);

    // 6: random stalls, mixed routed and DECERR traffic
    rdy_mode = 2;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(0, 5);
      id = 8'($urandom_range(1, 200));
      for (int i = 0; i <= len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        routed_beat(id, $urandom, i == len, 0);
      end
      if (b % 2 == 1) send_rc(8'(b), 8'($urandom_range(0, 4)), 1'b1, 0);
    end
    wait_drain(1000);
    rdy_mode = 0;
    chk("t6_rc_ready", rc_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
